// File: rtl/bnn_xnor_loader.sv
// ============================================================================
// Module  : bnn_xnor_loader
// Brief   : Byte loader for binarized activation/weight vectors with XNOR-popcount neuron
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bnn_xnor_loader #(
  parameter int N_BYTES = 4,
  parameter int THRESH  = 4 * N_BYTES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  input  logic                             in_sel,
  output logic                             in_ready,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(8*N_BYTES+1)-1:0]   popcount,
  output logic                             act_out,
  output logic                             err
);

  localparam int          c_pw       = $clog2(8 * N_BYTES + 1);
  localparam int          c_iw       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(N_BYTES - 1);
  localparam logic [31:0] c_thresh   = 32'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_act [N_BYTES];
  logic [7:0]      r_wgt [N_BYTES];
  logic [c_iw-1:0] r_act_idx;
  logic [c_iw-1:0] r_wgt_idx;
  logic            r_act_full;
  logic            r_wgt_full;
  logic [c_iw-1:0] r_k;
  logic [c_pw-1:0] r_acc;

  logic [7:0]      w_xnor;
  logic [3:0]      w_bits;
  logic [c_pw-1:0] w_acc_next;
  logic            w_start_ok;

  always_comb begin
    w_xnor = ~(r_act[r_k] ^ r_wgt[r_k]);
    w_bits = '0;
    for (int i = 0; i < 8; i++) begin
      w_bits = w_bits + {3'b000, w_xnor[i]};
    end
    w_acc_next = r_acc + c_pw'(w_bits);
    // Only flags registered before this edge qualify; a same-cycle write does not.
    w_start_ok = r_act_full && r_wgt_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      popcount   <= '0;
      act_out    <= 1'b0;
      r_act_idx  <= '0;
      r_wgt_idx  <= '0;
      r_act_full <= 1'b0;
      r_wgt_full <= 1'b0;
      r_k        <= '0;
      r_acc      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_sel) begin
              r_wgt[r_wgt_idx] <= in_data;
              if (r_wgt_idx == c_last_idx) begin
                r_wgt_idx  <= '0;
                r_wgt_full <= 1'b1;
              end else begin
                r_wgt_idx <= r_wgt_idx + c_iw'(1);
              end
            end else begin
              r_act[r_act_idx] <= in_data;
              if (r_act_idx == c_last_idx) begin
                r_act_idx  <= '0;
                r_act_full <= 1'b1;
              end else begin
                r_act_idx <= r_act_idx + c_iw'(1);
              end
            end
          end
          if (start) begin
            if (w_start_ok) begin
              r_state  <= S_COMPUTE;
              busy     <= 1'b1;
              in_ready <= 1'b0;
              r_acc    <= '0;
              r_k      <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_next;
          if (r_k == c_last_idx) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
          end else begin
            r_k <= r_k + c_iw'(1);
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          popcount   <= r_acc;
          act_out    <= (32'(r_acc) >= c_thresh);
          r_act_idx  <= '0;
          r_wgt_idx  <= '0;
          r_act_full <= 1'b0;
          r_wgt_full <= 1'b0;
          r_state    <= S_IDLE;
          in_ready   <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bnn_xnor_loader.sv
// ============================================================================
// Module  : tb_bnn_xnor_loader
// Brief   : Directed self-checking bench for bnn_xnor_loader (N_BYTES=4)
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bnn_xnor_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sel;
  logic       in_ready;
  logic       start;
  logic       busy;
  logic       done;
  logic [5:0] popcount;
  logic       act_out;
  logic       err;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  bnn_xnor_loader #(.N_BYTES(4), .THRESH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_ready (in_ready),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .popcount (popcount),
    .act_out  (act_out),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic sel, input logic [7:0] d);
    repeat (4) wr(sel, d);
  endtask

  // Issue an accepted start and measure done latency and busy width.
  task automatic run(input string tag, input int exp_pop, input logic exp_act);
    int lat;
    int nbusy;
    int c;
    lat   = 0;
    nbusy = 0;
    c     = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ready_low"}, 32'(in_ready), 0);
    if (busy) nbusy++;
    while (lat == 0 && c < 20) begin
      c++;
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (done) lat = c;
    end
    chk({tag, "_latency"}, 32'(lat), 5);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 4);
    chk({tag, "_pop"}, 32'(popcount), 32'(exp_pop));
    chk({tag, "_act"}, 32'(act_out), 32'(exp_act));
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(done), 0);
    chk({tag, "_pop_hold"}, 32'(popcount), 32'(exp_pop));
  endtask

  initial begin
    int ndone;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pop", 32'(popcount), 0);
    chk("rst_act", 32'(act_out), 0);
    rst = 1'b0;

    // All ones against all ones: every bit matches.
    load4(1'b0, 8'hFF);
    load4(1'b1, 8'hFF);
    run("ff_ff", 32, 1'b1);

    // All ones against all zeros: no bit matches.
    load4(1'b0, 8'hFF);
    load4(1'b1, 8'h00);
    run("ff_00", 0, 1'b0);

    // 0x0F vs 0xFF gives 4 matches per byte -> 16, exactly at threshold.
    load4(1'b0, 8'h0F);
    load4(1'b1, 8'hFF);
    run("0f_ff", 16, 1'b1);

    // Start with weight vector incomplete; the 4th weight byte arrives in the start cycle.
    load4(1'b0, 8'h3C);
    repeat (3) wr(1'b1, 8'h3C);
    start = 1'b1;
    wr(1'b1, 8'h00);
    start = 1'b0;
    chk("rej_err", 32'(err), 1);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("rej_err_pulse", 32'(err), 0);
    ndone = 0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("rej_no_done", 32'(ndone), 0);
    // The same-cycle write completed the weights, so a plain start now succeeds:
    // 3 bytes of 0xFF xnor -> 24, plus ~(0x3C^0x00)=0xC3 -> 4, total 28.
    run("late_wr", 28, 1'b1);

    // Reset two cycles into COMPUTE.
    load4(1'b0, 8'h5A);
    load4(1'b1, 8'h5A);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_pop", 32'(popcount), 0);
    chk("mid_act", 32'(act_out), 0);
    chk("mid_ready", 32'(in_ready), 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mid_restart_err", 32'(err), 1);
    chk("mid_restart_busy", 32'(busy), 0);

    // Fifth activation byte wraps and overwrites byte 0.
    wr(1'b0, 8'h00);
    repeat (4) wr(1'b0, 8'hFF);
    load4(1'b1, 8'hFF);
    run("wrap", 32, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
